// File: rtl/decoder_n_seq_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
package decoder_n_seq_pkg;

    localparam int MAX_OUT_W = 256;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    // Bit idx set when idx < width; callers size-cast the result to their own width.
    function automatic logic [MAX_OUT_W-1:0] onehot(input int idx, input int width);
        logic [MAX_OUT_W-1:0] r;
        for (int i = 0; i < MAX_OUT_W; i++)
            r[i] = (i < width) && (i == idx);
        return r;
    endfunction

endpackage

// File: rtl/decoder_n_seq_decoder_n.sv
// Combinational SEL_W -> 2^SEL_W one-hot decoder with enable.
module decoder_n
    import decoder_n_seq_pkg::*;
#(
    parameter int  SEL_W = 5,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic [SEL_W-1:0] idx,
    input  logic             en,
    output logic [OUT_W-1:0] d
);

    always_comb begin
        d = '0;
        if (en)
            d = OUT_W'(onehot(int'(idx), OUT_W));
    end

endmodule

// File: rtl/decoder_n_seq.sv
// Registered one-hot decoder with a self-running sweep sequencer.
// Build option: DECODER_N_SEQ_ZERO_REG_EN keeps index OUT_W-1 permanently deasserted.
module decoder_n_seq
    import decoder_n_seq_pkg::*;
#(
    parameter int  SEL_W = 5,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic             sweep_start,
    output logic [OUT_W-1:0] d,
    output logic             busy,
    output logic             done
);

`ifdef DECODER_N_SEQ_ZERO_REG_EN
    localparam int LAST = OUT_W - 2;
`else
    localparam int LAST = OUT_W - 1;
`endif
    // cnt already points one past the driven index, so the sweep ends when it reaches LAST+1
    localparam logic [SEL_W:0] CNT_END = (SEL_W+1)'(LAST + 1);

    state_t           state, state_nx;
    logic [SEL_W:0]   cnt, cnt_nx;
    logic [SEL_W-1:0] dec_idx;
    logic             dec_en;
    logic             direct_en;
    logic [OUT_W-1:0] dec_d;

`ifdef DECODER_N_SEQ_ZERO_REG_EN
    assign direct_en = en && (sel != '1);
`else
    assign direct_en = en;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dec_idx  = sel;
        dec_en   = 1'b0;
        case (state)
            IDLE: begin
                if (sweep_start) begin
                    state_nx = SWEEP;
                    cnt_nx   = (SEL_W+1)'(1);
                    dec_idx  = '0;
                    dec_en   = 1'b1;
                end else begin
                    dec_en   = direct_en;
                end
            end
            SWEEP: begin
                if (cnt == CNT_END) begin
                    state_nx = DONE;
                end else begin
                    dec_idx  = cnt[SEL_W-1:0];
                    dec_en   = 1'b1;
                    cnt_nx   = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    decoder_n #(.SEL_W(SEL_W)) u_dec (
        .idx (dec_idx),
        .en  (dec_en),
        .d   (dec_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            d     <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            d     <= dec_d;
        end
    end

    assign busy = (state == SWEEP);
    assign done = (state == DONE);

endmodule
